inference_scheduler: RTL and testbench

INFERENCE_SCHEDULER -- requirements
Module: inference_scheduler

---
 rtl/inference_scheduler.sv | 155 +++++++++++++++
 tb/tb_inference_scheduler.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inference_scheduler.sv
// Two-slot frame buffer feeding a single inference accelerator.
// Each response carries the result plus the requester's addresses back to the transmitter.
module inference_scheduler #(
  parameter int FRAME_BYTES    = 785,
  parameter int RESULT_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      FRAME_READY,
  input  logic [FRAME_BYTES*8-1:0]  DATA_FRAME,
  input  logic [31:0]               SRC_IP_ADDRESS,
  input  logic [47:0]               SRC_MAC_ADDRESS,
  output logic                      ACC_START,
  output logic [FRAME_BYTES*8-1:0]  ACC_FRAME,
  input  logic                      ACC_DONE,
  input  logic [RESULT_WIDTH-1:0]   ACC_RESULT,
  output logic                      TX_VALID,
  input  logic                      TX_READY,
  output logic [RESULT_WIDTH-1:0]   TX_RESULT,
  output logic [7:0]                TX_META,
  output logic [31:0]               TX_DST_IP,
  output logic [47:0]               TX_DST_MAC,
  output logic                      BUSY,
  output logic [CNT_WIDTH-1:0]      DROP_COUNT,
  output logic [CNT_WIDTH-1:0]      TIMEOUT_COUNT
);

  localparam int META_BYTE = FRAME_BYTES - 1;
  localparam int TMR_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_WIDTH-1:0] TMR_LAST = TMR_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_WIDTH-1:0] TMR_ONE  = TMR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START     = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [1:0] SEND      = 2'd3;

  logic [1:0]              state_reg, state_next;
  logic                    wr_ptr_reg, wr_ptr_next;
  logic                    rd_ptr_reg, rd_ptr_next;
  logic [1:0]              count_reg, count_next;
  logic [TMR_WIDTH-1:0]    tmr_reg, tmr_next;
  logic [RESULT_WIDTH-1:0] tx_result_reg, tx_result_next;
  logic [CNT_WIDTH-1:0]    drop_cnt_reg, drop_cnt_next;
  logic [CNT_WIDTH-1:0]    to_cnt_reg, to_cnt_next;
  logic                    push, pop, drop, timeout_hit;

  // Slot storage carries no reset; contents only matter while the slot is occupied.
  logic [FRAME_BYTES*8-1:0] frame_mem [0:1];
  logic [31:0]              ip_mem    [0:1];
  logic [47:0]              mac_mem   [0:1];

  always_comb begin
    state_next     = state_reg;
    tmr_next       = tmr_reg;
    tx_result_next = tx_result_reg;
    pop            = 1'b0;
    timeout_hit    = 1'b0;
    // Fullness is judged on the registered count, so a same-cycle pop never rescues a frame.
    push = FRAME_READY && (count_reg != 2'd2);
    drop = FRAME_READY && (count_reg == 2'd2);

    case (state_reg)
      IDLE: begin
        if (count_reg != 2'd0) state_next = START;
      end
      START: begin
        state_next = WAIT_DONE;
        tmr_next   = '0;
      end
      WAIT_DONE: begin
        if (ACC_DONE) begin
          tx_result_next = ACC_RESULT;
          state_next     = SEND;
        end else if (tmr_reg == TMR_LAST) begin
          pop         = 1'b1;
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end else begin
          tmr_next = tmr_reg + TMR_ONE;
        end
      end
      SEND: begin
        if (TX_READY) begin
          pop        = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    wr_ptr_next = push ? ~wr_ptr_reg : wr_ptr_reg;
    rd_ptr_next = pop  ? ~rd_ptr_reg : rd_ptr_reg;

    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + 2'd1;
    else if (pop && !push)
      count_next = count_reg - 2'd1;

    drop_cnt_next = drop_cnt_reg;
    if (drop && (drop_cnt_reg != CNT_MAX))
      drop_cnt_next = drop_cnt_reg + CNT_ONE;

    to_cnt_next = to_cnt_reg;
    if (timeout_hit && (to_cnt_reg != CNT_MAX))
      to_cnt_next = to_cnt_reg + CNT_ONE;
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      count_reg     <= 2'd0;
      tmr_reg       <= '0;
      tx_result_reg <= '0;
      drop_cnt_reg  <= '0;
      to_cnt_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      tmr_reg       <= tmr_next;
      tx_result_reg <= tx_result_next;
      drop_cnt_reg  <= drop_cnt_next;
      to_cnt_reg    <= to_cnt_next;
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) begin
      frame_mem[wr_ptr_reg] <= DATA_FRAME;
      ip_mem[wr_ptr_reg]    <= SRC_IP_ADDRESS;
      mac_mem[wr_ptr_reg]   <= SRC_MAC_ADDRESS;
    end
  end

  assign ACC_FRAME     = frame_mem[rd_ptr_reg];
  assign TX_META       = frame_mem[rd_ptr_reg][META_BYTE*8 +: 8];
  assign TX_DST_IP     = ip_mem[rd_ptr_reg];
  assign TX_DST_MAC    = mac_mem[rd_ptr_reg];
  assign ACC_START     = (state_reg == START);
  assign TX_VALID      = (state_reg == SEND);
  assign TX_RESULT     = tx_result_reg;
  assign BUSY          = (state_reg != IDLE) || (count_reg != 2'd0);
  assign DROP_COUNT    = drop_cnt_reg;
  assign TIMEOUT_COUNT = to_cnt_reg;

endmodule

// File: tb/tb_inference_scheduler.sv
// Bench for inference_scheduler: vector table, directed corner sequences and a
// randomized run scored against a transaction-queue reference model.
module tb_inference_scheduler;

  localparam int FB   = 785;
  localparam int META = FB - 1;
  localparam int TO   = 8;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  localparam int PH_IDLE  = 0;
  localparam int PH_START = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_SEND  = 3;

  logic            ACLK = 1'b0;
  logic            ARESET = 1'b1;
  logic            fr = 1'b0;
  logic [FB*8-1:0] frame_in = '0;
  logic [31:0]     ip_in = '0;
  logic [47:0]     mac_in = '0;
  logic            done = 1'b0;
  logic [7:0]      res = '0;
  logic            txr = 1'b0;

  logic            ACC_START, TX_VALID, BUSY;
  logic [FB*8-1:0] ACC_FRAME;
  logic [7:0]      TX_RESULT, TX_META;
  logic [31:0]     TX_DST_IP;
  logic [47:0]     TX_DST_MAC;
  logic [CW-1:0]   DROP_COUNT, TIMEOUT_COUNT;

  int total = 0;
  int bad = 0;

  inference_scheduler #(
    .FRAME_BYTES(FB), .RESULT_WIDTH(8), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .FRAME_READY(fr), .DATA_FRAME(frame_in),
    .SRC_IP_ADDRESS(ip_in), .SRC_MAC_ADDRESS(mac_in), .ACC_START(ACC_START),
    .ACC_FRAME(ACC_FRAME), .ACC_DONE(done), .ACC_RESULT(res), .TX_VALID(TX_VALID),
    .TX_READY(txr), .TX_RESULT(TX_RESULT), .TX_META(TX_META), .TX_DST_IP(TX_DST_IP),
    .TX_DST_MAC(TX_DST_MAC), .BUSY(BUSY), .DROP_COUNT(DROP_COUNT),
    .TIMEOUT_COUNT(TIMEOUT_COUNT)
  );

  always #5 ACLK = ~ACLK;

  // Reference model: queue of accepted frames plus the service phase of the head frame.
  typedef struct {
    logic [FB*8-1:0] frame;
    logic [31:0]     ip;
    logic [47:0]     mac;
  } slot_t;

  slot_t      q[$];
  int         ph, age, m_drop, m_to, n_resp;
  logic [7:0] m_result;

  typedef struct {
    bit         fr;
    bit         done;
    logic [7:0] res;
    bit         e_start;
    bit         e_valid;
    bit         e_busy;
    logic [7:0] e_result;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [FB*8-1:0] make_frame(input logic [7:0] meta);
    logic [FB*8-1:0] f;
    for (int i = 0; i < FB; i++) f[i*8 +: 8] = 8'($urandom_range(0, 255));
    f[META*8 +: 8] = meta;
    return f;
  endfunction

  task automatic m_reset();
    q.delete();
    ph = PH_IDLE;
    age = 0;
    m_drop = 0;
    m_to = 0;
    m_result = 8'h00;
  endtask

  task automatic model_check();
    chk("acc_start", 64'(ACC_START), 64'(ph == PH_START));
    chk("tx_valid", 64'(TX_VALID), 64'(ph == PH_SEND));
    chk("busy", 64'(BUSY), 64'((ph != PH_IDLE) || (q.size() != 0)));
    chk("tx_result", 64'(TX_RESULT), 64'(m_result));
    chk("drop_count", 64'(DROP_COUNT), 64'(m_drop));
    chk("timeout_count", 64'(TIMEOUT_COUNT), 64'(m_to));
    if (q.size() != 0) begin
      total++;
      if (ACC_FRAME !== q[0].frame) begin
        bad++;
        for (int i = 0; i < FB; i++) begin
          if (ACC_FRAME[i*8 +: 8] !== q[0].frame[i*8 +: 8]) begin
            $display("FAIL acc_frame byte %0d: got %02h want %02h", i,
                     ACC_FRAME[i*8 +: 8], q[0].frame[i*8 +: 8]);
            break;
          end
        end
      end
      chk("tx_meta", 64'(TX_META), 64'(q[0].frame[META*8 +: 8]));
      chk("tx_dst_ip", 64'(TX_DST_IP), 64'(q[0].ip));
      chk("tx_dst_mac", 64'(TX_DST_MAC), 64'(q[0].mac));
    end
  endtask

  task automatic model_step();
    int    n0;
    bit    pop;
    slot_t s;
    if (!ARESET) begin
      m_reset();
      return;
    end
    n0 = q.size();
    pop = 1'b0;
    case (ph)
      PH_IDLE: if (n0 > 0) ph = PH_START;
      PH_START: begin
        ph = PH_WAIT;
        age = 0;
      end
      PH_WAIT: begin
        if (done) begin
          m_result = res;
          ph = PH_SEND;
        end else if (age == TO - 1) begin
          pop = 1'b1;
          if (m_to < CMAX) m_to++;
          ph = PH_IDLE;
        end else begin
          age++;
        end
      end
      default: begin
        if (txr) begin
          n_resp++;
          $display("resp %0d: result=%02h meta=%02h ip=%08h", n_resp, m_result,
                   q[0].frame[META*8 +: 8], q[0].ip);
          pop = 1'b1;
          ph = PH_IDLE;
        end
      end
    endcase
    if (pop) q.delete(0);
    if (fr) begin
      if (n0 < 2) begin
        s.frame = frame_in;
        s.ip = ip_in;
        s.mac = mac_in;
        q.push_back(s);
      end else if (m_drop < CMAX) begin
        m_drop++;
      end
    end
  endtask

  // One clock: score outputs mid-cycle, advance the model with this cycle's inputs.
  task automatic tick();
    @(negedge ACLK);
    model_check();
    @(posedge ACLK);
    model_step();
    #1;
  endtask

  task automatic push_in(input logic [7:0] meta);
    fr = 1'b1;
    frame_in = make_frame(meta);
    ip_in = $urandom;
    mac_in = {16'($urandom), 32'($urandom)};
  endtask

  task automatic pulse_reset();
    ARESET = 1'b0;
    m_reset();
    #1;
    chk("rst_acc_start", 64'(ACC_START), 64'd0);
    chk("rst_tx_valid", 64'(TX_VALID), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_tx_result", 64'(TX_RESULT), 64'd0);
    chk("rst_drop", 64'(DROP_COUNT), 64'd0);
    chk("rst_timeout", 64'(TIMEOUT_COUNT), 64'd0);
    fr = 1'b0;
    done = 1'b0;
    txr = 1'b0;
    tick();
    ARESET = 1'b1;
  endtask

  initial begin
    logic [31:0] ip_a;

    for (int c = 0; c < 13; c++) tbl[c] = '{0, 0, 8'h00, 0, 0, 1, 8'h00};
    tbl[0]  = '{1, 0, 8'h00, 0, 0, 0, 8'h00};
    tbl[2]  = '{0, 0, 8'h00, 1, 0, 1, 8'h00};
    tbl[10] = '{0, 1, 8'h07, 0, 0, 1, 8'h00};
    tbl[11] = '{0, 0, 8'h00, 0, 1, 1, 8'h07};
    tbl[12] = '{0, 0, 8'h00, 0, 0, 0, 8'h07};

    n_resp = 0;
    m_reset();
    #2;
    pulse_reset();

    // Single frame latency; done lands on the last timer cycle so it must win over abort.
    frame_in = make_frame(8'h3C);
    ip_in = 32'h0A000005;
    mac_in = 48'h02AABBCCDDEE;
    for (int c = 0; c < 13; c++) begin
      chk($sformatf("v%0d_start", c), 64'(ACC_START), 64'(tbl[c].e_start));
      chk($sformatf("v%0d_valid", c), 64'(TX_VALID), 64'(tbl[c].e_valid));
      chk($sformatf("v%0d_busy", c), 64'(BUSY), 64'(tbl[c].e_busy));
      chk($sformatf("v%0d_result", c), 64'(TX_RESULT), 64'(tbl[c].e_result));
      if (c == 11) begin
        chk("v11_meta", 64'(TX_META), 64'h3C);
        chk("v11_ip", 64'(TX_DST_IP), 64'h0A000005);
        chk("v11_mac", 64'(TX_DST_MAC), 64'h02AABBCCDDEE);
      end
      $display("vec %0d: start=%0b valid=%0b busy=%0b result=%02h", c, ACC_START,
               TX_VALID, BUSY, TX_RESULT);
      fr = tbl[c].fr;
      done = tbl[c].done;
      res = tbl[c].res;
      txr = 1'b1;
      tick();
    end

    // Three back-to-back frames: third dropped, results in order.
    pulse_reset();
    for (int c = 0; c < 12; c++) begin
      case (c)
        3: chk("r21_drop", 64'(DROP_COUNT), 64'd1);
        6: begin
          chk("r21_valid1", 64'(TX_VALID), 64'd1);
          chk("r21_res1", 64'(TX_RESULT), 64'h11);
          chk("r21_meta1", 64'(TX_META), 64'h01);
        end
        10: begin
          chk("r21_valid2", 64'(TX_VALID), 64'd1);
          chk("r21_res2", 64'(TX_RESULT), 64'h22);
          chk("r21_meta2", 64'(TX_META), 64'h02);
        end
        11: chk("r21_busy", 64'(BUSY), 64'd0);
        default: ;
      endcase
      fr = 1'b0;
      done = 1'b0;
      txr = 1'b1;
      if (c < 3) push_in(8'(c + 1));
      if (c == 5) begin done = 1'b1; res = 8'h11; end
      if (c == 9) begin done = 1'b1; res = 8'h22; end
      tick();
    end

    // Accelerator silent: abort after TO wait cycles, next frame starts.
    pulse_reset();
    for (int c = 0; c < 16; c++) begin
      if (c <= 12) chk("r22_no_valid", 64'(TX_VALID), 64'd0);
      if (c == 10) chk("r22_to_before", 64'(TIMEOUT_COUNT), 64'd0);
      if (c == 11) chk("r22_to_count", 64'(TIMEOUT_COUNT), 64'd1);
      if (c == 12) begin
        chk("r22_start", 64'(ACC_START), 64'd1);
        chk("r22_meta", 64'(TX_META), 64'h0B);
      end
      if (c == 14) chk("r22_result", 64'(TX_RESULT), 64'h33);
      if (c == 15) chk("r22_busy", 64'(BUSY), 64'd0);
      fr = 1'b0;
      done = 1'b0;
      txr = 1'b1;
      if (c == 0) push_in(8'h0A);
      if (c == 1) push_in(8'h0B);
      if (c == 13) begin done = 1'b1; res = 8'h33; end
      tick();
    end

    // Back-pressure in SEND while a second frame arrives.
    pulse_reset();
    ip_a = '0;
    for (int c = 0; c < 15; c++) begin
      if (c >= 4 && c <= 9) begin
        chk("r23_valid", 64'(TX_VALID), 64'd1);
        chk("r23_result", 64'(TX_RESULT), 64'h5A);
        chk("r23_meta", 64'(TX_META), 64'hA1);
        chk("r23_ip", 64'(TX_DST_IP), 64'(ip_a));
      end
      if (c == 11) begin
        chk("r23_start2", 64'(ACC_START), 64'd1);
        chk("r23_meta2", 64'(TX_META), 64'hB2);
      end
      if (c == 13) chk("r23_result2", 64'(TX_RESULT), 64'h6B);
      if (c == 14) chk("r23_busy", 64'(BUSY), 64'd0);
      fr = 1'b0;
      done = 1'b0;
      txr = (c < 4) || (c >= 9);
      if (c == 0) begin push_in(8'hA1); ip_a = ip_in; end
      if (c == 5) push_in(8'hB2);
      if (c == 3) begin done = 1'b1; res = 8'h5A; end
      if (c == 12) begin done = 1'b1; res = 8'h6B; end
      tick();
    end

    // Full buffer with a frame arriving on the handshake edge: dropped.
    pulse_reset();
    for (int c = 0; c < 10; c++) begin
      if (c == 4) chk("r24_valid", 64'(TX_VALID), 64'd1);
      if (c == 5) chk("r24_drop", 64'(DROP_COUNT), 64'd1);
      if (c == 6) begin
        chk("r24_start", 64'(ACC_START), 64'd1);
        chk("r24_meta", 64'(TX_META), 64'hC2);
      end
      if (c == 8) chk("r24_result", 64'(TX_RESULT), 64'h55);
      if (c == 9) chk("r24_busy", 64'(BUSY), 64'd0);
      fr = 1'b0;
      done = 1'b0;
      txr = 1'b1;
      if (c == 0) push_in(8'hC1);
      if (c == 1) push_in(8'hC2);
      if (c == 4) push_in(8'hC3);
      if (c == 3) begin done = 1'b1; res = 8'h44; end
      if (c == 7) begin done = 1'b1; res = 8'h55; end
      tick();
    end

    // Reset mid-WAIT_DONE, then a stale completion.
    pulse_reset();
    for (int c = 0; c < 4; c++) begin
      fr = 1'b0;
      done = 1'b0;
      txr = 1'b1;
      if (c == 0) push_in(8'hD1);
      tick();
    end
    chk("r25_in_wait", 64'(BUSY), 64'd1);
    pulse_reset();
    for (int c = 0; c < 5; c++) begin
      fr = 1'b0;
      txr = 1'b1;
      done = (c == 0);
      res = 8'h77;
      tick();
      chk("r25_no_valid", 64'(TX_VALID), 64'd0);
      chk("r25_busy", 64'(BUSY), 64'd0);
      chk("r25_result", 64'(TX_RESULT), 64'd0);
    end

    // Randomized traffic with occasional resets.
    pulse_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        pulse_reset();
        continue;
      end
      fr = 1'b0;
      if ($urandom_range(0, 3) == 0) push_in(8'($urandom_range(0, 255)));
      done = ($urandom_range(0, 4) == 0);
      res = 8'($urandom_range(0, 255));
      txr = 1'($urandom_range(0, 1));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
